// File: rtl/motor_cmd_gen.sv
// Button-to-motor command generator: synchronizes and debounces three push-buttons and
// drives mutually exclusive forward/reverse levels with an enforced all-off dead-time.
module motor_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEADTIME_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_fwd,
  input  logic       btn_rev,
  input  logic       btn_stop,
  output logic       motor1,
  output logic       motor2,
  output logic       busy,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_FWD  = 2'b01;
  localparam logic [1:0] ST_REV  = 2'b10;
  localparam logic [1:0] ST_DEAD = 2'b11;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEADTIME_CYCLES - 1);

  // Button lanes: bit 0 = fwd, bit 1 = rev, bit 2 = stop.
  logic [2:0]            btn_raw;
  logic [2:0]            sync1_q, sync1_d;
  logic [2:0]            sync2_q, sync2_d;
  logic [2:0]            db_q, db_d;
  logic [2:0]            db_prev_q, db_prev_d;
  logic [2:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

  logic [1:0]       state_q, state_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0] dt_cnt_q, dt_cnt_d;
  logic             motor1_q, motor1_d;
  logic             motor2_q, motor2_d;
  logic             busy_q, busy_d;

  logic [2:0] req;
  logic       fwd_req, rev_req, stop_req;

  assign btn_raw = {btn_stop, btn_rev, btn_fwd};

  // Debounced level rises on the DEBOUNCE_CYCLES-th consecutive high sample, falls on any low one.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    for (int i = 0; i < 3; i++) begin
      db_d[i]     = 1'b0;
      db_cnt_d[i] = '0;
      if (sync2_q[i]) begin
        db_d[i]     = db_q[i] | (db_cnt_q[i] == DB_LAST);
        db_cnt_d[i] = (db_cnt_q[i] == DB_LAST) ? db_cnt_q[i] : db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign req      = db_q & ~db_prev_q;
  assign stop_req = req[2];
  assign fwd_req  = req[0] & ~req[2];
  assign rev_req  = req[1] & ~req[2] & ~req[0];

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    dt_cnt_d = dt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fwd_req)      state_d = ST_FWD;
        else if (rev_req) state_d = ST_REV;
      end
      ST_FWD: begin
        if (stop_req) begin
          state_d  = ST_DEAD;
          tgt_d    = ST_IDLE;
          dt_cnt_d = DT_LAST;
        end else if (rev_req) begin
          state_d  = ST_DEAD;
          tgt_d    = ST_REV;
          dt_cnt_d = DT_LAST;
        end
      end
      ST_REV: begin
        if (stop_req) begin
          state_d  = ST_DEAD;
          tgt_d    = ST_IDLE;
          dt_cnt_d = DT_LAST;
        end else if (fwd_req) begin
          state_d  = ST_DEAD;
          tgt_d    = ST_FWD;
          dt_cnt_d = DT_LAST;
        end
      end
      default: begin
        // Late requests retarget the exit but never extend the dead-time.
        if (stop_req)     tgt_d = ST_IDLE;
        else if (fwd_req) tgt_d = ST_FWD;
        else if (rev_req) tgt_d = ST_REV;
        if (dt_cnt_q == '0) state_d  = tgt_d;
        else                dt_cnt_d = dt_cnt_q - 1'b1;
      end
    endcase
    motor1_d = (state_d == ST_FWD);
    motor2_d = (state_d == ST_REV);
    busy_d   = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      db_cnt_q  <= '0;
      state_q   <= ST_IDLE;
      tgt_q     <= ST_IDLE;
      dt_cnt_q  <= '0;
      motor1_q  <= 1'b0;
      motor2_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      dt_cnt_q  <= dt_cnt_d;
      motor1_q  <= motor1_d;
      motor2_q  <= motor2_d;
      busy_q    <= busy_d;
    end
  end

  assign motor1 = motor1_q;
  assign motor2 = motor2_q;
  assign busy   = busy_q;
  assign state  = state_q;

endmodule

// File: tb/tb_motor_cmd_gen.sv
// Directed bench for motor_cmd_gen at default parameters (debounce 16, dead-time 8).
module tb_motor_cmd_gen;

  logic       clk;
  logic       rst;
  logic       btn_fwd, btn_rev, btn_stop;
  logic       motor1, motor2, busy;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  motor_cmd_gen dut (
    .clk     (clk),
    .rst     (rst),
    .btn_fwd (btn_fwd),
    .btn_rev (btn_rev),
    .btn_stop(btn_stop),
    .motor1  (motor1),
    .motor2  (motor2),
    .busy    (busy),
    .state   (state)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {motor1, motor2, busy, state}
  function automatic logic [7:0] outs();
    return {3'b000, motor1, motor2, busy, state};
  endfunction

  localparam logic [7:0] O_IDLE = 8'b000_000_00;
  localparam logic [7:0] O_FWD  = 8'b000_100_01;
  localparam logic [7:0] O_REV  = 8'b000_010_10;
  localparam logic [7:0] O_DEAD = 8'b000_001_11;

  // Driver tasks: inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] mask);
    {btn_stop, btn_rev, btn_fwd} = mask;
    repeat (19) tick();
    {btn_stop, btn_rev, btn_fwd} = 3'b000;
  endtask

  always @(negedge clk) check("excl", {7'b0, motor1 & motor2}, 8'h00);

  initial begin
    rst = 1'b1;
    {btn_stop, btn_rev, btn_fwd} = 3'b000;

    // 1. reset
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs", outs(), O_IDLE);
    end
    rst = 1'b0;
    tick();
    check("idle_after_rst", outs(), O_IDLE);

    // 2. forward press latency, held 40 cycles
    btn_fwd = 1'b1;
    repeat (18) tick();
    check("fwd_edge18", outs(), O_IDLE);
    tick();
    check("fwd_edge19", outs(), O_FWD);
    repeat (21) tick();
    btn_fwd = 1'b0;
    repeat (25) tick();
    check("fwd_hold_release", outs(), O_FWD);

    // 3. FWD -> REV with 8-cycle dead-time
    btn_rev = 1'b1;
    repeat (18) tick();
    check("rev_req_pre", outs(), O_FWD);
    tick();
    check("dead_c1", outs(), O_DEAD);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("dead_cn", outs(), O_DEAD);
    end
    tick();
    check("rev_entered", outs(), O_REV);
    btn_rev = 1'b0;
    repeat (25) tick();
    check("rev_hold", outs(), O_REV);

    // 4. back to FWD, then stop+rev together
    press(3'b001);
    check("rev_to_dead", outs(), O_DEAD);
    repeat (8) tick();
    check("back_fwd", outs(), O_FWD);
    press(3'b110);
    check("stoprev_dead", outs(), O_DEAD);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("stoprev_dead_n", outs(), O_DEAD);
    end
    tick();
    check("stoprev_idle", outs(), O_IDLE);
    repeat (25) tick();
    check("stoprev_idle_hold", outs(), O_IDLE);

    // stop in IDLE is ignored
    press(3'b100);
    check("stop_in_idle", outs(), O_IDLE);
    repeat (25) tick();

    // 5. stop during DEAD retargets without restarting the counter
    press(3'b001);
    check("t5_fwd", outs(), O_FWD);
    repeat (25) tick();
    btn_rev = 1'b1;
    repeat (2) tick();
    btn_stop = 1'b1;
    repeat (17) tick();
    check("t5_dead_c1", outs(), O_DEAD);
    btn_rev = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("t5_dead_n", outs(), O_DEAD);
    end
    btn_stop = 1'b0;
    tick();
    check("t5_exit_idle", outs(), O_IDLE);
    repeat (25) tick();
    check("t5_idle_hold", outs(), O_IDLE);

    // 6. short glitch, then reset from REV with fwd held
    btn_fwd = 1'b1;
    repeat (10) tick();
    btn_fwd = 1'b0;
    repeat (30) tick();
    check("glitch", outs(), O_IDLE);
    press(3'b010);
    check("t6_rev", outs(), O_REV);
    repeat (25) tick();
    rst     = 1'b1;
    btn_fwd = 1'b1;
    tick();
    check("rst_mid_rev", outs(), O_IDLE);
    tick();
    rst = 1'b0;
    repeat (18) tick();
    check("post_rst_edge18", outs(), O_IDLE);
    tick();
    check("post_rst_edge19", outs(), O_FWD);
    btn_fwd = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
